service_arbiter: RTL and testbench

Central controller that owns the shared 7-segment display, the push buttons and the mode LEDs on behalf of the four services (time set, alarm set, stopwatch, alarm check). It validates and debounces the SPDT service switches. It grants exactly one service at a time, lets an alarm match preempt the current service, and routes buttons only to the granted service. It also scans the display with the granted service's digits and blinks the digit under edit. It sits between the switch/button pins and the service modules, and drives `anode`, the digit code into NumTo7Segment, and `led[13:10]`.

---
 rtl/service_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_service_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/service_arbiter.sv
// service_arbiter
//   Central owner of the shared 7-segment display, push buttons and mode LEDs
//   on behalf of the four services (1 = time set, 2 = alarm set,
//   3 = stopwatch, 4 = alarm check). It filters the SPDT service switches,
//   grants one service at a time, lets an alarm match preempt the current
//   service, routes buttons to the granted service only, and scans the
//   granted service's digits onto the display with edit-digit blinking.
//
// Ports
//   clk, resetn         system clock, asynchronous active-low reset
//   spdt_service[3:0]   synchronized mode switches (bit 3 = service 1)
//   finish[3:0]         per-service done level, same bit order
//   alarm_req           high while current time equals alarm time
//   alarm_ack           one-cycle pulse from service 4 on alarm dismissal
//   push_in[4:0]        debounced buttons {m,r,l,d,u}
//   num1..num4[15:0]    BCD digits per service, [3:0] rightmost
//   sel1, sel2[3:0]     one-hot edit-digit position of services 1 and 2
//   scan_tick           strobe advancing the display scan position
//   blink               blink phase, 1 = edited digit dark
//   grant[3:0]          one-hot granted service, 0 = none
//   push_route[19:0]    {s1,s2,s3,s4} button slices
//   anode[3:0]          active-low digit enable
//   digit[3:0]          BCD code for NumTo7Segment
//   mode_led[3:0]       grant mirrored in RUN and ALARM
//   state[1:0]          IDLE=0, RUN=1, DONE=2, ALARM=3
module service_arbiter #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  spdt_service,
  input  logic [3:0]  finish,
  input  logic        alarm_req,
  input  logic        alarm_ack,
  input  logic [4:0]  push_in,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  input  logic [15:0] num3,
  input  logic [15:0] num4,
  input  logic [3:0]  sel1,
  input  logic [3:0]  sel2,
  input  logic        scan_tick,
  input  logic        blink,
  output logic [3:0]  grant,
  output logic [19:0] push_route,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic [3:0]  mode_led,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ALARM = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  s_q, s_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mask_q, mask_d;
  logic [1:0]  p_q, p_d;
  logic [19:0] route_q, route_d;
  logic [3:0]  anode_q, anode_d;
  logic [3:0]  digit_q, digit_d;

  logic        settled;
  logic        alarm_hit;
  logic [15:0] num_sel;
  logic [3:0]  sel_sel;
  logic        editable;

  // Switch stability filter: counts consecutive edges with an unchanged value.
  always_comb begin
    s_d = spdt_service;
    if (spdt_service != s_q) begin
      cnt_d = '0;
    end else if (cnt_q == SETTLE_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign settled   = (cnt_q == SETTLE_C);
  // A request seen at ack time stays masked until it has been low once.
  assign alarm_hit = alarm_req & ~mask_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mask_d  = mask_q;
    if (!alarm_req) begin
      mask_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (alarm_hit) begin
          state_d = ALARM;
          grant_d = 4'b0001;
        end else if (settled && $onehot(s_q)) begin
          state_d = RUN;
          grant_d = s_q;
        end
      end
      RUN: begin
        if (alarm_hit) begin
          state_d = ALARM;
          grant_d = 4'b0001;
        end else if (|(finish & grant_q)) begin
          state_d = DONE;
          grant_d = '0;
        end else if (spdt_service != grant_q) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      DONE: begin
        grant_d = '0;
        if (alarm_hit) begin
          state_d = ALARM;
          grant_d = 4'b0001;
        end else if (settled && (s_q == '0)) begin
          state_d = IDLE;
        end
      end
      ALARM: begin
        if (alarm_ack) begin
          state_d = IDLE;
          grant_d = '0;
          mask_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Button routing uses the grant held before the edge.
  always_comb begin
    route_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        route_d[i*5 +: 5] = push_in;
      end
    end
  end

  always_comb begin
    num_sel  = '0;
    sel_sel  = '0;
    editable = 1'b0;
    if (grant_q[3]) begin
      num_sel  = num1;
      sel_sel  = sel1;
      editable = 1'b1;
    end else if (grant_q[2]) begin
      num_sel  = num2;
      sel_sel  = sel2;
      editable = 1'b1;
    end else if (grant_q[1]) begin
      num_sel = num3;
    end else if (grant_q[0]) begin
      num_sel = num4;
    end
  end

  // Display uses the post-tick position so anode/digit lag scan_tick by one cycle.
  always_comb begin
    p_d     = p_q + {1'b0, scan_tick};
    anode_d = 4'b1111;
    digit_d = '0;
    if (|grant_q) begin
      anode_d = ~(4'b0001 << p_d);
      digit_d = num_sel[{p_d, 2'b00} +: 4];
      if (editable && blink && $onehot(sel_sel) && sel_sel[p_d]) begin
        anode_d = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      mask_q  <= 1'b0;
      p_q     <= '0;
      route_q <= '0;
      anode_q <= '1;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      p_q     <= p_d;
      route_q <= route_d;
      anode_q <= anode_d;
      digit_q <= digit_d;
    end
  end

  assign grant      = grant_q;
  assign push_route = route_q;
  assign anode      = anode_q;
  assign digit      = digit_q;
  assign state      = state_q;
  assign mode_led   = ((state_q == RUN) || (state_q == ALARM)) ? grant_q : '0;

endmodule

// File: tb/tb_service_arbiter.sv
// tb_service_arbiter
//   Self-checking bench for service_arbiter: a directed vector table, hand
//   sequences for display scan/blink and asynchronous reset, then randomized
//   traffic compared against a behavioural model.
module tb_service_arbiter;

  localparam int SETTLE = 4;

  logic        clk;
  logic        resetn;
  logic [3:0]  spdt_service;
  logic [3:0]  finish;
  logic        alarm_req;
  logic        alarm_ack;
  logic [4:0]  push_in;
  logic [15:0] num1, num2, num3, num4;
  logic [3:0]  sel1, sel2;
  logic        scan_tick;
  logic        blink;
  logic [3:0]  grant;
  logic [19:0] push_route;
  logic [3:0]  anode;
  logic [3:0]  digit;
  logic [3:0]  mode_led;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  service_arbiter #(.SETTLE(SETTLE)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .spdt_service (spdt_service),
    .finish       (finish),
    .alarm_req    (alarm_req),
    .alarm_ack    (alarm_ack),
    .push_in      (push_in),
    .num1         (num1),
    .num2         (num2),
    .num3         (num3),
    .num4         (num4),
    .sel1         (sel1),
    .sel2         (sel2),
    .scan_tick    (scan_tick),
    .blink        (blink),
    .grant        (grant),
    .push_route   (push_route),
    .anode        (anode),
    .digit        (digit),
    .mode_led     (mode_led),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States as plain ints: 0 idle, 1 run, 2 done, 3 alarm.
  int          m_state;
  logic [3:0]  m_grant;
  logic [3:0]  m_s;
  int          m_cnt;
  bit          m_mask;
  int          m_p;
  logic [19:0] m_route;
  logic [3:0]  m_anode;
  logic [3:0]  m_digit;

  always @(posedge clk or negedge resetn) begin : model
    int          ns;
    logic [3:0]  ng;
    bit          hit;
    int          svc;
    logic [15:0] nv;
    logic [3:0]  sv;
    if (!resetn) begin
      m_state = 0;
      m_grant = 4'h0;
      m_s     = 4'h0;
      m_cnt   = 0;
      m_mask  = 0;
      m_p     = 0;
      m_route = 20'h0;
      m_anode = 4'hF;
      m_digit = 4'h0;
    end else begin
      hit = alarm_req && !m_mask;
      ns  = m_state;
      ng  = m_grant;
      if (m_state == 3) begin
        if (alarm_ack) begin ns = 0; ng = 4'h0; end
      end else if (hit) begin
        ns = 3; ng = 4'b0001;
      end else if (m_state == 1) begin
        if ((finish & m_grant) != 4'h0) begin ns = 2; ng = 4'h0; end
        else if (spdt_service != m_grant) begin ns = 0; ng = 4'h0; end
      end else if (m_state == 2) begin
        if (m_s == 4'h0 && m_cnt == SETTLE) ns = 0;
      end else if (m_cnt == SETTLE && $countones(m_s) == 1) begin
        ns = 1; ng = m_s;
      end

      if (m_state == 3 && alarm_ack) m_mask = 1;
      else if (!alarm_req) m_mask = 0;

      // svc: 0 = service 1 ... 3 = service 4, -1 = none
      svc = -1;
      for (int k = 0; k < 4; k++) if (m_grant[3-k]) svc = k;

      m_route = 20'h0;
      if (svc >= 0) m_route = 20'(push_in) << (5 * (3 - svc));

      m_p = (m_p + int'(scan_tick)) % 4;
      if (svc < 0) begin
        m_anode = 4'hF;
        m_digit = 4'h0;
      end else begin
        case (svc)
          0: nv = num1;
          1: nv = num2;
          2: nv = num3;
          default: nv = num4;
        endcase
        sv = (svc == 0) ? sel1 : (svc == 1) ? sel2 : 4'h0;
        m_digit = 4'((nv >> (4 * m_p)) & 16'hF);
        m_anode = ~(4'b0001 << m_p);
        if (svc < 2 && blink && $countones(sv) == 1 && sv[m_p]) m_anode = 4'hF;
      end

      if (spdt_service == m_s) begin
        if (m_cnt < SETTLE) m_cnt++;
      end else begin
        m_cnt = 0;
      end
      m_s     = spdt_service;
      m_state = ns;
      m_grant = ng;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  spdt;
    logic [3:0]  fin;
    logic        req;
    logic        ack;
    logic [4:0]  push;
    int          cyc;
    logic [1:0]  st;
    logic [3:0]  gr;
    logic [3:0]  led;
    logic [19:0] route;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] sp, input logic [3:0] fi,
                              input logic rq, input logic ak, input logic [4:0] pu,
                              input int cy, input logic [1:0] st, input logic [3:0] gr,
                              input logic [3:0] ld, input logic [19:0] rt);
    vec_t v;
    v.spdt = sp; v.fin = fi; v.req = rq; v.ack = ak; v.push = pu;
    v.cyc = cy; v.st = st; v.gr = gr; v.led = ld; v.route = rt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_an[4];
    logic [3:0] exp_dg[4];
    bit         reached;

    resetn = 1'b0; spdt_service = '0; finish = '0; alarm_req = 1'b0;
    alarm_ack = 1'b0; push_in = '0; num1 = 16'h1234; num2 = 16'h5678;
    num3 = 16'h9012; num4 = 16'h3456; sel1 = '0; sel2 = '0;
    scan_tick = 1'b0; blink = 1'b0;

    // Vector table: inputs held for cyc edges, then state/grant/led/route.
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 5'b00000,  3, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b1000, 4'b0000, 0, 0, 5'b00000,  5, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b1000, 4'b0000, 0, 0, 5'b00000,  1, 2'd1, 4'b1000, 4'b1000, 20'h00000));
    vecs.push_back(mk(4'b1000, 4'b0000, 0, 0, 5'b00001,  1, 2'd1, 4'b1000, 4'b1000, 20'h08000));
    vecs.push_back(mk(4'b1000, 4'b0000, 0, 0, 5'b00000,  1, 2'd1, 4'b1000, 4'b1000, 20'h00000));
    vecs.push_back(mk(4'b1000, 4'b1000, 0, 0, 5'b00000,  1, 2'd2, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b1000, 4'b0000, 0, 0, 5'b00000, 20, 2'd2, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 5'b00000,  5, 2'd2, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 5'b00000,  1, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(4'b0100, 4'b0000, 0, 0, 5'b00000, 2, 2'd0, 4'b0000, 4'b0000, 20'h00000));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 5'b00000, 2, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    end
    vecs.push_back(mk(4'b1100, 4'b0000, 0, 0, 5'b00000, 10, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 0, 0, 5'b00000,  6, 2'd1, 4'b0010, 4'b0010, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0010, 1, 0, 5'b00000,  1, 2'd3, 4'b0001, 4'b0001, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0010, 1, 0, 5'b00000,  3, 2'd3, 4'b0001, 4'b0001, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 0, 5'b10101,  1, 2'd3, 4'b0001, 4'b0001, 20'h00015));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 1, 5'b00000,  1, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 0, 5'b00000,  1, 2'd1, 4'b0010, 4'b0010, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 0, 5'b00000,  3, 2'd1, 4'b0010, 4'b0010, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 0, 0, 5'b00000,  1, 2'd1, 4'b0010, 4'b0010, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 1, 0, 5'b00000,  1, 2'd3, 4'b0001, 4'b0001, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 0, 1, 5'b00000,  1, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b0010, 4'b0000, 0, 0, 5'b00000,  1, 2'd1, 4'b0010, 4'b0010, 20'h00000));
    vecs.push_back(mk(4'b0100, 4'b0000, 0, 0, 5'b00000,  1, 2'd0, 4'b0000, 4'b0000, 20'h00000));
    vecs.push_back(mk(4'b0100, 4'b0000, 0, 0, 5'b00000,  1, 2'd0, 4'b0000, 4'b0000, 20'h00000));

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_route", 32'(push_route), 32'd0);
    check("reset_anode", 32'(anode), 32'hF);
    check("reset_digit", 32'(digit), 32'd0);
    check("reset_led", 32'(mode_led), 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      spdt_service = vecs[i].spdt;
      finish       = vecs[i].fin;
      alarm_req    = vecs[i].req;
      alarm_ack    = vecs[i].ack;
      push_in      = vecs[i].push;
      repeat (vecs[i].cyc) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].gr));
      check($sformatf("vec%0d_led", i), 32'(mode_led), 32'(vecs[i].led));
      check($sformatf("vec%0d_route", i), 32'(push_route), 32'(vecs[i].route));
    end
    finish = '0; alarm_req = 1'b0; alarm_ack = 1'b0; push_in = '0;

    // Scan and blink on service 1 with num1 = 1234.
    spdt_service = 4'b1000;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      step();
      if (state == 2'd1) reached = 1;
    end
    check("scan_run_wait", 32'(reached), 32'd1);
    step();
    check("scan_p0_anode", 32'(anode), 32'hE);
    check("scan_p0_digit", 32'(digit), 32'h4);
    exp_an = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_dg = '{4'h3, 4'h2, 4'h1, 4'h4};
    for (int i = 0; i < 4; i++) begin
      scan_tick = 1'b1;
      step();
      scan_tick = 1'b0;
      check($sformatf("scan%0d_anode", i), 32'(anode), 32'(exp_an[i]));
      check($sformatf("scan%0d_digit", i), 32'(digit), 32'(exp_dg[i]));
    end
    sel1 = 4'b0010; blink = 1'b1; scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    check("blink_anode", 32'(anode), 32'hF);
    check("blink_digit", 32'(digit), 32'h3);
    sel1 = 4'b0110;
    step();
    check("blink_multihot_anode", 32'(anode), 32'hD);
    sel1 = 4'b0010; blink = 1'b0;
    step();
    check("blink_off_anode", 32'(anode), 32'hD);

    // Asynchronous reset mid-RUN, sampled between clock edges.
    #1 resetn = 1'b0;
    #1;
    check("areset_state", 32'(state), 32'd0);
    check("areset_grant", 32'(grant), 32'd0);
    check("areset_anode", 32'(anode), 32'hF);
    check("areset_led", 32'(mode_led), 32'd0);
    check("areset_route", 32'(push_route), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sel1 = '0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(5))
          0: spdt_service = 4'b0000;
          1: spdt_service = 4'b1000;
          2: spdt_service = 4'b0100;
          3: spdt_service = 4'b0010;
          4: spdt_service = 4'b0001;
          default: spdt_service = 4'($urandom);
        endcase
      end
      finish    = ($urandom_range(15) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(24) == 0) alarm_req = ~alarm_req;
      alarm_ack = ($urandom_range(11) == 0);
      push_in   = 5'($urandom);
      scan_tick = ($urandom_range(2) == 0);
      blink     = 1'($urandom);
      sel1      = ($urandom_range(3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(3));
      sel2      = ($urandom_range(3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(3));
      if ($urandom_range(19) == 0) begin
        num1 = 16'($urandom); num2 = 16'($urandom);
        num3 = 16'($urandom); num4 = 16'($urandom);
      end
      step();
      check("rnd_state", 32'(state), 32'(m_state));
      check("rnd_grant", 32'(grant), 32'(m_grant));
      check("rnd_led", 32'(mode_led), (m_state == 1 || m_state == 3) ? 32'(m_grant) : 32'd0);
      check("rnd_route", 32'(push_route), 32'(m_route));
      check("rnd_anode", 32'(anode), 32'(m_anode));
      check("rnd_digit", 32'(digit), 32'(m_digit));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
